if_id_queue: RTL and testbench

- Decoupling buffer between the fetch stage and the decode stage: a small FIFO of {PC+4, instruction} pairs.
- Lets fetch continue while decode is frozen by the hazard unit.
- Discards all wrong-path entries in one cycle when a branch is taken.
- Its `in_ready` output is inverted by the top level to form the fetch stage's freeze input.

---
 rtl/arm_pkg.sv | 23 ++
 rtl/queue_storage.sv | 27 ++
 rtl/if_id_queue.sv | 151 +++++++++++++++
 tb/tb_if_id_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: word width, NOP encoding,
// queue entry layout and a saturating-add helper used by the optional statistics counters.
package arm_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instruction;
    } if_id_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[32]) begin
            sat_add32 = 32'hFFFF_FFFF;
        end else begin
            sat_add32 = sum[31:0];
        end
    endfunction

endpackage

// File: rtl/queue_storage.sv
// Entry array for the IF/ID queue: one synchronous write port, one asynchronous read port.
// The array carries no reset; validity is tracked by the owner's count.
module queue_storage #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO of {PC+4, instruction} pairs with registered head outputs and
// single-cycle flush. Define IF_ID_QUEUE_STATS_EN to add flushed-entry / full-cycle counters.
module if_id_queue
    import arm_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int WORD_W = arm_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [WORD_W-1:0] instruction_in,
    output logic              in_ready,
    input  logic              freeze,
    input  logic              flush,
    output logic              out_valid,
    output logic [WORD_W-1:0] pc_out,
`ifdef IF_ID_QUEUE_STATS_EN
    output logic [31:0]       stat_flushed,
    output logic [31:0]       stat_full_cycles,
`endif
    output logic [WORD_W-1:0] instruction_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]    r_count;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic                r_out_valid;
    logic                r_in_ready;
    logic [WORD_W-1:0]   r_pc_out;
    logic [WORD_W-1:0]   r_instr_out;

    logic                w_push;
    logic                w_pop;
    logic                w_bypass;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [PTR_W-1:0]    w_rd_ptr_nxt;
    logic [PTR_W-1:0]    w_wr_ptr_nxt;
    logic [2*WORD_W-1:0] w_rd_data;

    // Handshake, next occupancy and pointer advance
    always_comb begin
        w_push       = in_valid & r_in_ready & ~flush;
        w_pop        = r_out_valid & ~freeze & ~flush;
        w_count_nxt  = r_count;
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
        if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end
        // The incoming entry becomes the head when nothing older remains after this pop.
        w_bypass = w_push & (w_rd_ptr_nxt == r_wr_ptr);
    end

    queue_storage #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * WORD_W)
    ) u_storage (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({pc_in, instruction_in}),
        .i_rd_addr (w_rd_ptr_nxt),
        .o_rd_data (w_rd_data)
    );

    // Occupancy, pointers and registered head outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_pc_out    <= '0;
            r_instr_out <= WORD_W'(NOP_INSTR);
        end else if (flush) begin
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_instr_out <= WORD_W'(NOP_INSTR);
        end else begin
            r_count     <= w_count_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_out_valid <= (w_count_nxt != CNT_W'(0));
            r_in_ready  <= (w_count_nxt < CNT_W'(DEPTH));
            if (w_count_nxt == CNT_W'(0)) begin
                r_pc_out    <= r_pc_out;
                r_instr_out <= r_instr_out;
            end else if (w_bypass) begin
                r_pc_out    <= pc_in;
                r_instr_out <= instruction_in;
            end else begin
                r_pc_out    <= w_rd_data[2*WORD_W-1:WORD_W];
                r_instr_out <= w_rd_data[WORD_W-1:0];
            end
        end
    end

    assign in_ready        = r_in_ready;
    assign out_valid       = r_out_valid;
    assign pc_out          = r_pc_out;
    assign instruction_out = r_instr_out;

`ifdef IF_ID_QUEUE_STATS_EN
    logic [31:0] r_stat_flushed;
    logic [31:0] r_stat_full_cycles;

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_flushed     <= 32'h0000_0000;
            r_stat_full_cycles <= 32'h0000_0000;
        end else begin
            if (flush) begin
                r_stat_flushed <= sat_add32(r_stat_flushed, 32'(r_count));
            end else begin
                r_stat_flushed <= r_stat_flushed;
            end
            if (r_count == CNT_W'(DEPTH)) begin
                r_stat_full_cycles <= sat_add32(r_stat_full_cycles, 32'h0000_0001);
            end else begin
                r_stat_full_cycles <= r_stat_full_cycles;
            end
        end
    end

    assign stat_flushed     = r_stat_flushed;
    assign stat_full_cycles = r_stat_full_cycles;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=2); stats checks compile in with
// IF_ID_QUEUE_STATS_EN.
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] pc_in;
    logic [31:0] instruction_in;
    logic        in_ready;
    logic        freeze;
    logic        flush;
    logic        out_valid;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
`ifdef IF_ID_QUEUE_STATS_EN
    logic [31:0] stat_flushed;
    logic [31:0] stat_full_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_id_queue #(.DEPTH(2), .WORD_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .pc_in           (pc_in),
        .instruction_in  (instruction_in),
        .in_ready        (in_ready),
        .freeze          (freeze),
        .flush           (flush),
        .out_valid       (out_valid),
        .pc_out          (pc_out),
`ifdef IF_ID_QUEUE_STATS_EN
        .stat_flushed    (stat_flushed),
        .stat_full_cycles(stat_full_cycles),
`endif
        .instruction_out (instruction_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid       = v;
        pc_in          = pc;
        instruction_in = ins;
    endtask

    initial begin
        rst = 1'b1;
        freeze = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_instr", instruction_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // single push
        drive(1'b1, 32'd4, 32'hE3A00001);
        tick();
        check("push_valid", 32'(out_valid), 32'd1);
        check("push_pc", pc_out, 32'd4);
        check("push_instr", instruction_out, 32'hE3A00001);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("pop_empty", 32'(out_valid), 32'd0);

        // fill under freeze
        freeze = 1'b1;
        drive(1'b1, 32'd8, 32'hA);
        tick();
        check("fill1_valid", 32'(out_valid), 32'd1);
        check("fill1_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'd12, 32'hB);
        tick();
        check("fill2_ready", 32'(in_ready), 32'd0);
        check("fill2_pc", pc_out, 32'd8);
        check("fill2_instr", instruction_out, 32'hA);
        drive(1'b1, 32'd16, 32'hC);
        tick();
        check("full_hold_pc", pc_out, 32'd8);
        check("full_hold_ready", 32'(in_ready), 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        freeze = 1'b0;
        tick();
        check("drain1_pc", pc_out, 32'd12);
        check("drain1_instr", instruction_out, 32'hB);
        check("drain1_ready", 32'(in_ready), 32'd1);
        tick();
        check("drain2_valid", 32'(out_valid), 32'd0);

        // streaming: one-cycle latency, occupancy stays at one
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'(4 * i), 32'(i));
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pc", pc_out, 32'(4 * i));
            check("stream_instr", instruction_out, 32'(i));
            check("stream_ready", 32'(in_ready), 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("stream_end", 32'(out_valid), 32'd0);

        // flush with concurrent push
        freeze = 1'b1;
        drive(1'b1, 32'd200, 32'hC0);
        tick();
        drive(1'b1, 32'd204, 32'hD0);
        tick();
        check("preflush_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'd100, 32'h64);
        tick();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_instr", instruction_out, 32'h0);
        flush = 1'b0;
        freeze = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("flush_dropped", 32'(out_valid), 32'd0);
        drive(1'b1, 32'd300, 32'h12C);
        tick();
        check("postflush_pc", pc_out, 32'd300);
        check("postflush_instr", instruction_out, 32'h12C);
        drive(1'b0, 32'h0, 32'h0);
        tick();

        // asynchronous reset mid-stream
        freeze = 1'b1;
        drive(1'b1, 32'd400, 32'h190);
        tick();
        drive(1'b1, 32'd404, 32'h194);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("prerst_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b0;
        freeze = 1'b0;

`ifdef IF_ID_QUEUE_STATS_EN
        freeze = 1'b1;
        drive(1'b1, 32'd500, 32'h1);
        tick();
        drive(1'b1, 32'd504, 32'h2);
        tick();
        flush = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        flush = 1'b0;
        check("stat_flushed", stat_flushed, 32'd2);
        check("stat_full_a", stat_full_cycles, 32'd1);
        drive(1'b1, 32'd508, 32'h3);
        tick();
        drive(1'b1, 32'd512, 32'h4);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        tick();
        check("stat_full_b", stat_full_cycles, 32'd4);
        check("stat_flushed_hold", stat_flushed, 32'd2);
        freeze = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
